// File: rtl/rede_io_sched.sv
// Processor I/O scheduler: per-port input holding registers with read strobes,
// per-port output capture registers drained round-robin into one host slot.
module rede_io_sched #(
    parameter int NUBITS = 31,
    parameter int NPORT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [1:0]               in_port,
    input  logic signed [NUBITS-1:0] in_data,
    output logic                     in_ready,
    input  logic [NPORT-1:0]         req_in,
    output logic signed [NUBITS-1:0] io_in,
    input  logic [NPORT-1:0]         out_en,
    input  logic signed [NUBITS-1:0] io_out,
    output logic                     out_valid,
    output logic [1:0]               out_port,
    output logic signed [NUBITS-1:0] out_data,
    input  logic                     out_ready,
    input  logic                     clr_err,
    output logic                     underrun,
    output logic                     overrun
);

    logic [NPORT-1:0][NUBITS-1:0] data_q, cap_q;
    logic [NPORT-1:0]             full, pending;
    logic [1:0]                   rr_ptr;

    logic       rd_any, wr_any, in_acc, load_slot, grant;
    logic [1:0] rd_idx, wr_idx, win, scan_idx;
    logic       found;
    logic [NPORT-1:0] eff;
    logic       ev_un, ev_ov;

    assign in_ready = ~full[in_port];
    assign in_acc   = in_valid & in_ready;
    assign rd_any   = |req_in;
    assign wr_any   = |out_en;

    // Descending scan so the lowest set strobe bit is the one served.
    always_comb begin
        rd_idx = '0;
        wr_idx = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req_in[i]) rd_idx = i[1:0];
            if (out_en[i]) wr_idx = i[1:0];
        end
    end

    assign io_in = (rd_any && full[rd_idx]) ? signed'(data_q[rd_idx]) : '0;
    assign ev_un = rd_any && !full[rd_idx];

    // A capture this cycle competes too, so an empty slot shows it one cycle later.
    always_comb begin
        eff = pending;
        if (wr_any) eff[wr_idx] = 1'b1;
        win      = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            scan_idx = rr_ptr + i[1:0];
            if (!found && eff[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
    end

    assign load_slot = !out_valid || out_ready;
    assign grant     = load_slot && found;
    assign ev_ov     = wr_any && pending[wr_idx] && !(grant && win == wr_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_port  <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                if (in_acc && in_port == k[1:0]) begin
                    data_q[k] <= in_data;
                    full[k]   <= 1'b1;
                end else if (rd_any && rd_idx == k[1:0]) begin
                    full[k] <= 1'b0;
                end
                // A grant of a non-pending port consumes the capture directly.
                if (wr_any && wr_idx == k[1:0]) begin
                    cap_q[k]   <= io_out;
                    pending[k] <= !(grant && win == k[1:0] && !pending[k]);
                end else if (grant && win == k[1:0]) begin
                    pending[k] <= 1'b0;
                end
            end
            if (load_slot) begin
                out_valid <= grant;
                if (grant) begin
                    out_port <= win;
                    out_data <= pending[win] ? signed'(cap_q[win]) : io_out;
                    rr_ptr   <= win + 2'd1;
                end
            end
            underrun <= ev_un || (underrun && !clr_err);
            overrun  <= ev_ov || (overrun && !clr_err);
        end
    end

endmodule

// File: doc/rede_io_sched.md
REDE_IO_SCHED -- requirements
Module: rede_io_sched

Interface
REQ-001 Parameter NUBITS, default 31, meaning data word width, signed.
REQ-002 Parameter NPORT, fixed 4, meaning processor I/O ports per direction; port index is 2 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  host offers an input sample.
REQ-006 in_port  input  2  destination input port of the offered sample.
REQ-007 in_data  input  NUBITS  offered sample, signed.
REQ-008 in_ready  output  1  sample accepted this cycle when high together with in_valid.
REQ-009 req_in  input  4  one-hot processor input-read strobe, decoded by addr_dec.
REQ-010 io_in  output  NUBITS  sample presented to the processor, combinational.
REQ-011 out_en  input  4  one-hot processor output-write strobe, decoded by addr_dec.
REQ-012 io_out  input  NUBITS  processor output word, valid while out_en is non-zero.
REQ-013 out_valid  output  1  host output sample available.
REQ-014 out_port  output  2  source port of the host output sample.
REQ-015 out_data  output  NUBITS  host output sample.
REQ-016 out_ready  input  1  host consumes the sample when high together with out_valid.
REQ-017 clr_err  input  1  clears the sticky error flags.
REQ-018 underrun  output  1  sticky: processor read an empty input port.
REQ-019 overrun  output  1  sticky: processor overwrote an undelivered output sample.

Function
REQ-020 Input side: one holding register and a full flag per port.
REQ-021 in_ready shall equal NOT full[in_port]; there is no bypass path.
REQ-022 On an accepted host write, data[in_port] is loaded and full[in_port] is set at the next edge.
REQ-023 io_in shall be data[k] when req_in bit k is set and full[k]=1; otherwise io_in shall be 0. Latency is zero (combinational).
REQ-024 On a req_in bit k cycle, full[k] is cleared at the next edge.
REQ-025 A req_in bit k with full[k]=0 shall set underrun.
REQ-026 A host write and a req_in to the same empty port in the same cycle: io_in=0, underrun is set, and the written data is stored with full set.
REQ-027 A req_in value that is not one-hot and not zero: only the lowest set bit is served.
REQ-028 Output side: one capture register and a pending flag per port.
REQ-029 out_en bit k loads cap[k] from io_out and sets pending[k] at the next edge. A non-one-hot out_en is handled per REQ-027.
REQ-030 The output stage is a single registered slot (out_valid, out_port, out_data).
REQ-031 The slot loads when out_valid=0 or (out_valid AND out_ready), using the round-robin winner among the pending ports.
- Search starts at rr_ptr.
- The winner's pending flag is cleared.
- rr_ptr becomes winner+1 modulo 4.
REQ-032 When no port is pending at a slot-load opportunity, out_valid is deasserted (or stays 0).
REQ-033 Minimum latency is out_en at cycle t to out_valid at cycle t+1. Back-to-back delivery of one sample per cycle shall be possible when out_ready is held high.
REQ-034 Capture and grant of the same port in the same cycle: the grant takes the old cap[k], the new data is captured, pending[k] stays set, and no overrun is flagged.
REQ-035 out_en bit k with pending[k]=1 and no simultaneous grant of port k: data is overwritten and overrun is set.
REQ-036 out_data and out_port shall be held stable while out_valid=1 and out_ready=0.
REQ-037 clr_err clears underrun and overrun at the next edge. An error event in the same cycle takes priority, so the flag stays set.

Reset
REQ-038 While rst=1 at an edge, the following are cleared:
- all full and pending flags
- out_valid, out_port, out_data
- rr_ptr (to 0)
- underrun and overrun
REQ-039 rst has priority over every other input. Samples in flight when reset is asserted are discarded.
REQ-040 In the first cycle after reset, in_ready=1, io_in=0 and out_valid=0.

Verification
REQ-041 Write 5 to port 2, then req_in=0100 two cycles later: io_in=5 in that cycle, full[2] is cleared, in_ready for port 2 returns to 1, underrun=0.
REQ-042 req_in=0001 with port 0 empty: io_in=0 and underrun=1. Then clr_err=1 for one cycle: underrun=0.
REQ-043 out_en=0001, 0010, 0100, 1000 on consecutive cycles with data 10..13 and out_ready=1: out_port 0,1,2,3 with data 10..13 on cycles t+1..t+4, overrun=0.
REQ-044 All four ports pending and rr_ptr=2, with out_ready=1: grant order is 2,3,0,1.
REQ-045 out_ready=0, port 1 pending with value 7, then out_en=0010 with value 9: overrun=1, and port 1 later delivers 9.
REQ-046 rst asserted while out_valid=1 and port 3 full: next cycle out_valid=0, in_ready=1 for all ports, and no stale data is delivered.
